// File: rtl/bus_dma_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared constants, register map and FSM encoding for the
//                bus_dma_master copy engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

  // Slave register byte offsets inside the 16-byte window
  localparam logic [3:0] DMA_SRC  = 4'h0;
  localparam logic [3:0] DMA_DST  = 4'h4;
  localparam logic [3:0] DMA_LEN  = 4'h8;
  localparam logic [3:0] DMA_CTRL = 4'hc;

  // CTRL write bits and STATUS read bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_FILL     = 2;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;

  // Base address used by the SoC-level slave decode
  localparam logic [31:0] DMA_BASE_ADDR = 32'h8000_0020;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_t;

  // Byte-lane merge of a bus write into an existing register value
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dma_master_regs.sv
`default_nettype none
// ============================================================================
//  Module      : dma_regs
//  Description : CPU-facing register file (SRC/DST/LEN/CTRL) with a registered
//                one-cycle ready handshake. Produces the START strobe and the
//                latched configuration for the transfer FSM.
//                Optional feature macro: DMA_FILL_EN (pattern fill mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_regs
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_sel,
  input  logic [3:0]           i_addr,
  input  logic [3:0]           i_wstrb,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata,
  output logic                 o_ready,
  input  logic                 i_busy,
  input  logic                 i_fin,
  input  logic [LEN_WIDTH-1:0] i_cnt,
  input  logic                 i_fill_q,
  output logic [31:0]          o_src,
  output logic [31:0]          o_dst,
  output logic [LEN_WIDTH-1:0] o_len,
  output logic [31:0]          o_pattern,
  output logic                 o_start,
  output logic                 o_fill
);

  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_done;

  logic        w_acc;
  logic        w_wr;
  logic        w_cfg_wr;
  logic        w_ctrl_wr;
  logic        w_clr;
  logic [31:0] w_src_wr;
  logic [31:0] w_dst_wr;
  logic [31:0] w_len_wr;
  logic [31:0] w_cnt32;
  logic [31:0] w_status;
  logic [31:0] w_rd_mux;
  logic        w_unused_bits;

  // An access is accepted only when ready is low, so a held select cannot
  // produce a second pulse back-to-back.
  assign w_acc     = i_sel & ~r_ready;
  assign w_wr      = w_acc & (|i_wstrb);
  assign w_cfg_wr  = w_wr & ~i_busy;
  assign w_ctrl_wr = w_wr & (i_addr[3:2] == DMA_CTRL[3:2]) & i_wstrb[0];
  assign w_clr     = w_ctrl_wr & i_wdata[CTRL_CLR_DONE];
  assign o_start   = w_ctrl_wr & i_wdata[CTRL_START] & ~i_busy;

  assign w_src_wr = merge_bytes(r_src, i_wdata, i_wstrb);
  assign w_dst_wr = merge_bytes(r_dst, i_wdata, i_wstrb);
  assign w_len_wr = merge_bytes(32'(r_len), i_wdata, i_wstrb);
  assign w_cnt32  = 32'(i_cnt);
  assign w_status = {w_cnt32[15:0], 13'd0, i_fill_q, r_done, i_busy};

  assign w_unused_bits = &{1'b0, i_addr[1:0], w_len_wr, w_cnt32};

  // Read data multiplexer for the four registers
  always_comb begin
    w_rd_mux = 32'd0;
    case (i_addr[3:2])
      DMA_SRC[3:2]:  w_rd_mux = r_src;
      DMA_DST[3:2]:  w_rd_mux = r_dst;
      DMA_LEN[3:2]:  w_rd_mux = 32'(r_len);
      default:       w_rd_mux = w_status;
    endcase
  end

  // Register file, handshake and sticky DONE flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_src   <= 32'd0;
      r_dst   <= 32'd0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rd_mux : 32'd0;
      if (w_cfg_wr && (i_addr[3:2] == DMA_SRC[3:2])) r_src <= w_src_wr & 32'hffff_fffc;
      if (w_cfg_wr && (i_addr[3:2] == DMA_DST[3:2])) r_dst <= w_dst_wr & 32'hffff_fffc;
      if (w_cfg_wr && (i_addr[3:2] == DMA_LEN[3:2])) r_len <= w_len_wr[LEN_WIDTH-1:0];
      if (i_fin) begin
        r_done <= 1'b1;
      end else if (w_clr || o_start) begin
        r_done <= 1'b0;
      end
    end
  end

`ifdef DMA_FILL_EN
  logic [31:0] r_pattern;

  // The fill pattern keeps all 32 written bits; only the address view is aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= 32'd0;
    end else if (w_cfg_wr && (i_addr[3:2] == DMA_SRC[3:2])) begin
      r_pattern <= w_src_wr;
    end
  end

  assign o_pattern = r_pattern;
  assign o_fill    = i_wdata[CTRL_FILL];
`else
  assign o_pattern = r_src;
  assign o_fill    = 1'b0;
`endif

  assign o_rdata = r_rdata;
  assign o_ready = r_ready;
  assign o_src   = r_src;
  assign o_dst   = r_dst;
  assign o_len   = r_len;

endmodule
`default_nettype wire

// File: rtl/bus_dma_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus_dma_master
//  Description : Memory-to-memory copy engine. CPU programs SRC/DST/LEN via a
//                4-register slave port; the master port issues one read then
//                one write per 32-bit word on a valid/ready memory bus.
//                Optional feature macro: DMA_FILL_EN (pattern fill mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_dma_master
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        dma_ready,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        irq_done
);

  dma_state_t           r_state;
  logic                 r_m_valid;
  logic [31:0]          r_m_addr;
  logic [31:0]          r_m_wdata;
  logic [3:0]           r_m_wstrb;
  logic [31:0]          r_cur_src;
  logic [31:0]          r_cur_dst;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [31:0]          r_buf;
  logic                 r_fill;
  logic                 r_irq;

  logic                 w_busy;
  logic                 w_fin;
  logic                 w_start;
  logic                 w_fill;
  logic [31:0]          w_src;
  logic [31:0]          w_dst;
  logic [LEN_WIDTH-1:0] w_len;
  logic [31:0]          w_pattern;

  assign w_busy = (r_state != ST_IDLE);
  assign w_fin  = (r_state == ST_FIN);

  dma_regs #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .i_sel     (dma_sel),
    .i_addr    (addr),
    .i_wstrb   (wstrb),
    .i_wdata   (data_i),
    .o_rdata   (data_o),
    .o_ready   (dma_ready),
    .i_busy    (w_busy),
    .i_fin     (w_fin),
    .i_cnt     (r_cnt),
    .i_fill_q  (r_fill),
    .o_src     (w_src),
    .o_dst     (w_dst),
    .o_len     (w_len),
    .o_pattern (w_pattern),
    .o_start   (w_start),
    .o_fill    (w_fill)
  );

  // Transfer FSM: each bus request is raised in one cycle and held until
  // m_ready, then dropped, which leaves an idle cycle between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_m_valid <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_m_wstrb <= 4'd0;
      r_cur_src <= 32'd0;
      r_cur_dst <= 32'd0;
      r_cnt     <= '0;
      r_buf     <= 32'd0;
      r_fill    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cur_src <= w_src;
            r_cur_dst <= w_dst;
            r_cnt     <= w_len;
            r_fill    <= w_fill;
            r_buf     <= w_pattern;
            if (w_len == '0)  r_state <= ST_FIN;
            else if (w_fill)  r_state <= ST_WR;
            else              r_state <= ST_RD;
          end
        end
        ST_RD: begin
          if (!r_m_valid) begin
            r_m_valid <= 1'b1;
            r_m_addr  <= r_cur_src;
            r_m_wstrb <= 4'h0;
          end else if (m_ready) begin
            r_buf     <= m_rdata;
            r_m_valid <= 1'b0;
            r_state   <= ST_WR;
          end
        end
        ST_WR: begin
          if (!r_m_valid) begin
            r_m_valid <= 1'b1;
            r_m_addr  <= r_cur_dst;
            r_m_wdata <= r_buf;
            r_m_wstrb <= 4'hf;
          end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_wstrb <= 4'h0;
            r_cur_dst <= r_cur_dst + 32'd4;
            if (!r_fill) r_cur_src <= r_cur_src + 32'd4;
            r_cnt <= r_cnt - LEN_WIDTH'(1);
            if (r_cnt == LEN_WIDTH'(1)) r_state <= ST_FIN;
            else if (r_fill)            r_state <= ST_WR;
            else                        r_state <= ST_RD;
          end
        end
        ST_FIN: begin
          r_irq   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_valid  = r_m_valid;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_wstrb  = r_m_wstrb;
  assign irq_done = r_irq;

endmodule
`default_nettype wire
